// File: rtl/store_byte_serializer.sv
// store_byte_serializer
//   Breaks one 32-bit store (sb/sh/sw) into 1, 2 or 4 byte writes on a
//   byte-wide memory port. It accepts one request at a time and rejects
//   misaligned or reserved-size requests with a one-cycle error pulse.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   store request handshake (ready only in IDLE)
//   req_addr          byte address of the store
//   req_data          register data (low bytes used for sb/sh)
//   req_size          00 byte, 01 half, 10 word, 11 reserved
//   mem_we/addr/wdata byte write presented to memory
//   mem_ready         memory accepts the current byte this cycle
//   done              one-cycle pulse when the last byte has been accepted
//   misalign_err      one-cycle pulse when a request is rejected
//   dbg_state         current FSM state (IDLE=0, WRITE=1, ERR=2)
//
// Handshake semantics: a transfer happens on a rising edge where valid and
// ready are both high. The request side holds no obligations after the
// transfer. On the memory side, mem_addr/mem_wdata stay stable while
// mem_we=1 and mem_ready=0; a byte is consumed on mem_we & mem_ready.

module store_byte_serializer #(
   parameter int ADDR_W     = 32,
   parameter int BIG_ENDIAN = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_data,
   input  logic [1:0]        req_size,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic              mem_ready,
   output logic              done,
   output logic              misalign_err,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ERR   = 2'd2
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [1:0]        idx;
   logic [1:0]        last_idx;

   // Byte lane emitted at write index i. In big-endian mode the lanes are
   // emitted most-significant first, so the lane is mirrored about last.
   function automatic logic [7:0] pick_byte(input logic [31:0] d,
                                            input logic [1:0]  i,
                                            input logic [1:0]  last);
      logic [1:0] lane;
      lane = (BIG_ENDIAN != 0) ? (last - i) : i;
      case (lane)
         2'd0:    pick_byte = d[7:0];
         2'd1:    pick_byte = d[15:8];
         2'd2:    pick_byte = d[23:16];
         default: pick_byte = d[31:24];
      endcase
   endfunction

   // Decode of the incoming request.
   logic       req_illegal;
   logic [1:0] req_last;
   logic [1:0] idx_next;

   always_comb begin
      req_illegal = 1'b0;
      req_last    = 2'd0;
      case (req_size)
         2'b00: req_last = 2'd0;
         2'b01: begin
            req_last    = 2'd1;
            req_illegal = req_addr[0];
         end
         2'b10: begin
            req_last    = 2'd3;
            req_illegal = (req_addr[1:0] != 2'b00);
         end
         default: begin
            req_last    = 2'd0;
            req_illegal = 1'b1;
         end
      endcase
   end

   assign idx_next  = idx + 2'd1;
   assign dbg_state = state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         req_ready    <= 1'b1;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 8'h00;
         done         <= 1'b0;
         misalign_err <= 1'b0;
         addr_q       <= '0;
         data_q       <= 32'h0;
         idx          <= 2'd0;
         last_idx     <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               done         <= 1'b0;
               misalign_err <= 1'b0;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  addr_q    <= req_addr;
                  data_q    <= req_data;
                  last_idx  <= req_last;
                  idx       <= 2'd0;
                  if (req_illegal) begin
                     state        <= ERR;
                     misalign_err <= 1'b1;
                     mem_we       <= 1'b0;
                  end else begin
                     // First byte is taken straight from the request so it
                     // can appear in the cycle after acceptance.
                     state     <= WRITE;
                     mem_we    <= 1'b1;
                     mem_addr  <= req_addr;
                     mem_wdata <= pick_byte(req_data, 2'd0, req_last);
                  end
               end
            end

            WRITE: begin
               if (mem_ready) begin
                  if (idx == last_idx) begin
                     state     <= IDLE;
                     mem_we    <= 1'b0;
                     done      <= 1'b1;
                     req_ready <= 1'b1;
                  end else begin
                     idx       <= idx_next;
                     // Aligned stores never carry out of the low bits, but the
                     // sum still wraps naturally at the address width.
                     mem_addr  <= addr_q + {{(ADDR_W-2){1'b0}}, idx_next};
                     mem_wdata <= pick_byte(data_q, idx_next, last_idx);
                  end
               end
            end

            ERR: begin
               misalign_err <= 1'b0;
               mem_we       <= 1'b0;
               req_ready    <= 1'b1;
               state        <= IDLE;
            end

            default: begin
               state     <= IDLE;
               mem_we    <= 1'b0;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/store_byte_serializer.md
Name: store_byte_serializer

Overview:
- Store-side counterpart of the load-path sign extender: narrows a 32-bit register store (sb/sh/sw) into individual byte writes on the 8-bit data-memory port.
- Accepts one store request per handshake and checks its alignment.
- Emits 1, 2 or 4 byte writes, one per accepted memory cycle, then signals completion.
- Sits between the CPU store datapath and the byte-wide RAM controller.

Parameters:
ADDR_W, 32, width of request and memory addresses
BIG_ENDIAN, 0, 0 = byte k of data goes to addr+k (little-endian); 1 = byte k goes to addr+(n-1-k)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  store request present
req_ready  output  1  serializer can accept a request (high only in IDLE)
req_addr  input  ADDR_W  byte address of store
req_data  input  32  register data; low bytes used for sb/sh
req_size  input  2  00 byte, 01 half, 10 word, 11 reserved
mem_we  output  1  byte write valid on memory port
mem_addr  output  ADDR_W  byte write address
mem_wdata  output  8  byte write data
mem_ready  input  1  memory accepts current byte this cycle
done  output  1  one-cycle pulse: store fully written
misalign_err  output  1  one-cycle pulse: request rejected (misaligned or size 11)

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, done=0, misalign_err=0.
  - Internal address/data/count registers cleared.
- Acceptance: req_valid & req_ready at a rising edge latches addr, data and size; req_ready drops the next cycle.
- Byte count n: 1 for size 00, 2 for 01, 4 for 10.
- Illegal request, i.e. size 11, size 01 with addr[0]=1, or size 10 with addr[1:0]!=0:
  - Next cycle: state=ERR, misalign_err=1, mem_we=0.
  - Following cycle: IDLE. No memory writes are issued.
- Legal request, state WRITE:
  - mem_we=1 from the cycle after acceptance.
  - Byte index i starts at 0; mem_addr = latched addr + i.
  - mem_wdata = data[8i+7:8i] (little-endian), or data[8(n-1-i)+7:8(n-1-i)] when BIG_ENDIAN=1.
  - Outputs are registered and held stable while mem_we=1 & mem_ready=0 (stall of any length).
  - On mem_we & mem_ready: i increments and the next byte appears the following cycle.
  - On the ack of byte n-1: next cycle state=IDLE, mem_we=0, done=1 for exactly one cycle.
- Latency with mem_ready tied high:
  - Accept at edge T; bytes occupy cycles T+1..T+n.
  - done and req_ready=1 in cycle T+n+1.
  - A new request may be accepted in that same cycle (done and acceptance coexist).
- Requests while busy are ignored: req_ready=0 and the request is not latched.
- Address increment wraps modulo 2^ADDR_W. Cannot occur for aligned stores; a documented no-op boundary.
- done and misalign_err are never high together. mem_we is never high in IDLE or ERR.
- Reset mid-WRITE: writes abort immediately (mem_we=0 asynchronously), no done pulse, partial bytes remain in memory.
- Input changes on req_* after acceptance have no effect.

Test Plan:
- Reset then sw, addr=0x100, data=0x11223344, mem_ready=1 -> 4 writes: (0x100,44), (0x101,33), (0x102,22), (0x103,11) on consecutive cycles; done pulse in the next cycle.
- sh, addr=0x202, data=0xAABBCCDD with mem_ready low 3 cycles on the first byte -> (0x202,DD) held 4 cycles, then (0x203,CC), then done.
- sb, addr=0x3, data=0x000000F7 -> single write (0x3,F7), done 2 cycles after acceptance; back-to-back sb accepted in the done cycle.
- sw at addr=0x102, sh at addr=0x1, and size=11 -> misalign_err one-cycle pulse each, mem_we never asserted, req_ready high again 2 cycles after acceptance.
- BIG_ENDIAN=1, sw addr=0x40, data=0x11223344 -> (0x40,11), (0x41,22), (0x42,33), (0x43,44).
- rst_n low after 2 bytes of sw -> mem_we falls immediately, no done, outputs at reset values; next sb completes normally.
